// File: rtl/pixel_kernel_multiplier.sv
// Pixel-by-kernel product stage feeding the transposed-convolution decoder.
// Define SIGNED_MULT_EN for two's-complement operands; the default build multiplies unsigned operands.
module pixel_kernel_multiplier #(
  parameter int N      = 2,
  parameter int K      = 3,
  parameter int ILEN   = 8,
  parameter int OLEN   = 16,
  parameter int stride = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ILEN-1:0]           input_image [0:N*N-1],
  input  logic [ILEN-1:0]           kernel [0:K*K-1],
  input  logic                      decoding_complete,
  output logic [$clog2(N*N)-1:0]    state,
  output logic [OLEN-1:0]           multiplied_image [0:K*K-1],
  output logic                      enable,
  output logic                      busy,
  output logic                      done
);

  localparam int SW  = $clog2(N*N);
  localparam int PIW = $clog2(K*K) + 1;
  localparam int IW  = (K*K > 1) ? $clog2(K*K) : 1;
  // stride only rides along in the parameter list, so it contributes nothing here
  localparam int MAXW = ((OLEN > 2*ILEN) ? OLEN : 2*ILEN) + 0 * stride;

  typedef enum logic [2:0] {IDLE, LOAD, MULT, ISSUE, WAIT, DONE} fsm_t;

  fsm_t             fsm;
  logic [ILEN-1:0]  kernel_q [0:K*K-1];
  logic [ILEN-1:0]  pixel_q;
  logic [PIW-1:0]   prod_idx;
  logic [ILEN-1:0]  weight;
  logic [MAXW-1:0]  op_a;
  logic [MAXW-1:0]  op_b;
  logic [MAXW-1:0]  product;

  assign weight = kernel_q[prod_idx[IW-1:0]];

  // Operands are widened before multiplying so the low OLEN bits come out already extended
  always_comb begin
`ifdef SIGNED_MULT_EN
    op_a = {{(MAXW-ILEN){pixel_q[ILEN-1]}}, pixel_q};
    op_b = {{(MAXW-ILEN){weight[ILEN-1]}}, weight};
`else
    op_a = {{(MAXW-ILEN){1'b0}}, pixel_q};
    op_b = {{(MAXW-ILEN){1'b0}}, weight};
`endif
    product = op_a * op_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      state    <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pixel_q  <= '0;
      prod_idx <= '0;
      for (int i = 0; i < K*K; i++) begin
        kernel_q[i]         <= '0;
        multiplied_image[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < K*K; i++) kernel_q[i] <= kernel[i];
            state <= '0;
            busy  <= 1'b1;
            fsm   <= LOAD;
          end
        end
        LOAD: begin
          pixel_q  <= input_image[state];
          prod_idx <= '0;
          fsm      <= MULT;
        end
        MULT: begin
          multiplied_image[prod_idx[IW-1:0]] <= product[OLEN-1:0];
          prod_idx <= prod_idx + 1'b1;
          if (prod_idx == PIW'(K*K-1)) fsm <= ISSUE;
        end
        ISSUE: begin
          enable <= 1'b1;
          fsm    <= WAIT;
        end
        // Outputs stay frozen here until the decoder reports it has consumed them
        WAIT: begin
          if (decoding_complete) begin
            enable <= 1'b0;
            if (state == SW'(N*N-1)) begin
              fsm <= DONE;
            end else begin
              state <= state + 1'b1;
              fsm   <= LOAD;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_kernel_multiplier.sv
// Scoreboard bench for pixel_kernel_multiplier: expected products are queued per pixel at start
// and checked when enable rises, with a decoder model answering after a chosen delay.
module tb_pixel_kernel_multiplier;

  localparam int N    = 2;
  localparam int K    = 3;
  localparam int ILEN = 8;
  localparam int OLEN = 16;
  localparam int NP   = N*N;
  localparam int KK   = K*K;
  localparam int SW   = $clog2(NP);
  localparam int CW   = KK*OLEN;

  typedef logic [CW-1:0] cval_t;
  typedef struct packed {
    logic [SW-1:0] st;
    logic [CW-1:0] prods;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            decoding_complete;
  logic [ILEN-1:0] input_image [0:NP-1];
  logic [ILEN-1:0] kernel [0:KK-1];
  logic [SW-1:0]   state;
  logic [OLEN-1:0] multiplied_image [0:KK-1];
  logic            enable;
  logic            busy;
  logic            done;
  logic [CW-1:0]   got_prods;
  logic [CW-1:0]   first_prods;

  exp_t sb[$];
  int   tests = 0;
  int   failures = 0;
  int   done_count = 0;
  int   cyc = 0;
  int   t_ref = 0;

  pixel_kernel_multiplier #(.N(N), .K(K), .ILEN(ILEN), .OLEN(OLEN), .stride(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .input_image(input_image),
    .kernel(kernel),
    .decoding_complete(decoding_complete),
    .state(state),
    .multiplied_image(multiplied_image),
    .enable(enable),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_count++;

  always_comb begin
    got_prods = '0;
    for (int i = 0; i < KK; i++) got_prods[i*OLEN +: OLEN] = multiplied_image[i];
  end

  function automatic logic [OLEN-1:0] model(input logic [ILEN-1:0] p, input logic [ILEN-1:0] w);
    int r;
`ifdef SIGNED_MULT_EN
    r = int'($signed(p)) * int'($signed(w));
`else
    r = int'(p) * int'(w);
`endif
    return r[OLEN-1:0];
  endfunction

  task automatic checkOutput(input string tag, input cval_t got, input cval_t exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives image and kernel, queues the expected products of every pixel, then pulses start
  task automatic applyStimulus(input logic [NP*ILEN-1:0] imgp, input logic [KK*ILEN-1:0] kerp);
    exp_t e;
    for (int i = 0; i < NP; i++) input_image[i] = imgp[i*ILEN +: ILEN];
    for (int k = 0; k < KK; k++) kernel[k] = kerp[k*ILEN +: ILEN];
    for (int p = 0; p < NP; p++) begin
      e.st = SW'(p);
      for (int k = 0; k < KK; k++) e.prods[k*OLEN +: OLEN] = model(input_image[p], kernel[k]);
      sb.push_back(e);
    end
    start = 1'b1;
    t_ref = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Decoder model: answers each enable after 'delay' cycles, optionally injecting stray start/decoding_complete
  task automatic servePass(input int delay, input bit stray, input bit capture);
    exp_t e;
    int   waited;
    bit   held;
    for (int p = 0; p < NP; p++) begin
      waited = 0;
      while (enable !== 1'b1 && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (enable !== 1'b1) begin
        checkOutput("enable_timeout", cval_t'(0), cval_t'(1));
        return;
      end
      checkOutput($sformatf("latency_p%0d", p), cval_t'(cyc - t_ref), cval_t'(KK + 3));
      if (sb.size() == 0) begin
        checkOutput("sb_empty", cval_t'(0), cval_t'(1));
        return;
      end
      e = sb.pop_front();
      checkOutput($sformatf("state_p%0d", p), cval_t'(state), cval_t'(e.st));
      checkOutput($sformatf("prods_p%0d", p), got_prods, e.prods);
      checkOutput($sformatf("busy_p%0d", p), cval_t'(busy), cval_t'(1));
      if (capture && p == 0) first_prods = got_prods;
      held = 1'b1;
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        start = stray && (i == 2);
        if (enable !== 1'b1 || state !== e.st || got_prods !== e.prods) held = 1'b0;
      end
      start = 1'b0;
      checkOutput($sformatf("hold_p%0d", p), cval_t'(held), cval_t'(1));
      decoding_complete = 1'b1;
      t_ref = cyc;
      @(negedge clk);
      decoding_complete = 1'b0;
      checkOutput($sformatf("enable_drop_p%0d", p), cval_t'(enable), cval_t'(0));
      if (stray && p < NP-1) begin
        @(negedge clk);
        @(negedge clk);
        decoding_complete = 1'b1;
        @(negedge clk);
        decoding_complete = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("done_pulse", cval_t'(done), cval_t'(1));
    checkOutput("busy_fall", cval_t'(busy), cval_t'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NP*ILEN-1:0] img;
    logic [KK*ILEN-1:0] ker;
    logic [KK*ILEN-1:0] ker2;
    int                 dc0;
    int                 waited;

    rst_n = 1'b0;
    start = 1'b0;
    decoding_complete = 1'b0;
    for (int i = 0; i < NP; i++) input_image[i] = '0;
    for (int k = 0; k < KK; k++) kernel[k] = '0;
    #12;
    checkOutput("rst_enable", cval_t'(enable), cval_t'(0));
    checkOutput("rst_busy", cval_t'(busy), cval_t'(0));
    checkOutput("rst_done", cval_t'(done), cval_t'(0));
    checkOutput("rst_state", cval_t'(state), cval_t'(0));
    checkOutput("rst_prods", got_prods, cval_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass: kernel 1..9, image 1..4, decoder answers after 11 cycles
    for (int i = 0; i < NP; i++) img[i*ILEN +: ILEN] = ILEN'(i + 1);
    for (int k = 0; k < KK; k++) ker[k*ILEN +: ILEN] = ILEN'(k + 1);
    dc0 = done_count;
    applyStimulus(img, ker);
    servePass(11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t2_done_once", cval_t'(done_count - dc0), cval_t'(1));

    // Slow decoder: outputs must hold for 50 cycles per pixel
    for (int i = 0; i < NP; i++) img[i*ILEN +: ILEN] = ILEN'(8'h11 * (i + 3));
    applyStimulus(img, ker);
    servePass(50, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Stray start and decoding_complete while busy
    for (int i = 0; i < NP; i++) img[i*ILEN +: ILEN] = ILEN'(i + 1);
    dc0 = done_count;
    applyStimulus(img, ker);
    servePass(11, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t4_done_once", cval_t'(done_count - dc0), cval_t'(1));

    // Back-to-back passes; the kernel input is scrambled after the second start
    for (int k = 0; k < KK; k++) ker2[k*ILEN +: ILEN] = ILEN'(8'h20 + 3*k);
    dc0 = done_count;
    applyStimulus(img, ker);
    servePass(5, 1'b0, 1'b0);
    applyStimulus(img, ker2);
    for (int k = 0; k < KK; k++) kernel[k] = 8'hA5;
    servePass(5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t5_done_twice", cval_t'(done_count - dc0), cval_t'(2));

    // Extreme operands exercise sign handling
    img = {8'h7F, 8'h80, 8'h01, 8'hFF};
    ker = {8'h81, 8'h7F, 8'hFE, 8'h10, 8'h03, 8'h01, 8'h80, 8'hFF, 8'h02};
    applyStimulus(img, ker);
    servePass(3, 1'b0, 1'b1);
`ifdef SIGNED_MULT_EN
    checkOutput("t6_ff_x_02", cval_t'(first_prods[OLEN-1:0]), cval_t'(16'hFFFE));
`else
    checkOutput("t6_ff_x_02", cval_t'(first_prods[OLEN-1:0]), cval_t'(16'h01FE));
`endif
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a pass
    img = {8'h04, 8'h03, 8'h02, 8'h01};
    for (int k = 0; k < KK; k++) ker[k*ILEN +: ILEN] = ILEN'(k + 1);
    applyStimulus(img, ker);
    waited = 0;
    while (enable !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t1_enable_before_reset", cval_t'(enable), cval_t'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_enable", cval_t'(enable), cval_t'(0));
    checkOutput("t1_busy", cval_t'(busy), cval_t'(0));
    checkOutput("t1_done", cval_t'(done), cval_t'(0));
    checkOutput("t1_state", cval_t'(state), cval_t'(0));
    checkOutput("t1_prods", got_prods, cval_t'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dc0 = done_count;
    repeat (20) @(negedge clk);
    checkOutput("t1_idle_enable", cval_t'(enable), cval_t'(0));
    checkOutput("t1_idle_busy", cval_t'(busy), cval_t'(0));
    checkOutput("t1_no_done", cval_t'(done_count - dc0), cval_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
